// File: rtl/window_sequencer_if.sv
// Handshake bundle between the window sequencer and its pixel datapath.
// The sequencer owns the master side; the datapath owns the slave side.
interface window_sequencer_if #(
   parameter int KSIZE = 3,
   parameter int IMG_W = 64,
   parameter int IMG_H = 48
);
   localparam int TW = $clog2(KSIZE);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   logic          start;
   logic          abort;
   logic          param_done;
   logic          read_data_done;
   logic          load_done;
   logic          calc_done;
   logic          write_done;
   logic          load_initial;
   logic          start_read;
   logic          start_load;
   logic          start_shift;
   logic          start_calc;
   logic          start_write;
   logic [TW-1:0] tap_row;
   logic [TW-1:0] tap_col;
   logic [XW-1:0] win_x;
   logic [YW-1:0] win_y;
   logic          busy;
   logic          done;

   modport master (
      input  start, abort,
      input  param_done, read_data_done,
      input  load_done, calc_done, write_done,
      output load_initial, start_read,
      output start_load, start_shift,
      output start_calc, start_write,
      output tap_row, tap_col,
      output win_x, win_y,
      output busy, done
   );

   modport slave (
      output start, abort,
      output param_done, read_data_done,
      output load_done, calc_done, write_done,
      input  load_initial, start_read,
      input  start_load, start_shift,
      input  start_calc, start_write,
      input  tap_row, tap_col,
      input  win_x, win_y,
      input  busy, done
   );
endinterface

// File: rtl/window_sequencer.sv
// Sliding-window frame sequencer: walks a KSIZE x KSIZE window over the
// image, fetching taps and issuing calc/write requests per position.
module window_sequencer #(
   parameter int KSIZE = 3,
   parameter int IMG_W = 64,
   parameter int IMG_H = 48
) (
   input logic clk,
   input logic rst,
   window_sequencer_if.master bus
);
   localparam int TW = $clog2(KSIZE);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   localparam logic [TW-1:0] T_MAX = TW'(KSIZE - 1);
   localparam logic [XW-1:0] X_MAX = XW'(IMG_W - KSIZE);
   localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - KSIZE);

   typedef enum logic [3:0] {
      IDLE,
      PARAM_REQ,
      PARAM_WAIT,
      RD_REQ,
      RD_WAIT,
      LD_REQ,
      LD_WAIT,
      CALC_REQ,
      CALC_WAIT,
      WR_REQ,
      WR_WAIT,
      ADV
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] row_q, row_d;
   logic [TW-1:0] col_q, col_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          shift_q, shift_d;
   logic          last_tap;

   // Shift loads pin col to T_MAX, so one test covers both load kinds.
   assign last_tap = (row_q == T_MAX) && (col_q == T_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         shift_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         x_q     <= x_d;
         y_q     <= y_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      row_d            = row_q;
      col_d            = col_q;
      x_d              = x_q;
      y_d              = y_q;
      shift_d          = shift_q;
      bus.load_initial = 1'b0;
      bus.start_read   = 1'b0;
      bus.start_load   = 1'b0;
      bus.start_shift  = 1'b0;
      bus.start_calc   = 1'b0;
      bus.start_write  = 1'b0;
      bus.done         = 1'b0;

      if (bus.abort && state_q != IDLE) begin
         // Abort suppresses this cycle's pulses and drops the frame.
         state_d = IDLE;
         row_d   = '0;
         col_d   = '0;
         x_d     = '0;
         y_d     = '0;
         shift_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start && !bus.abort)
                  state_d = PARAM_REQ;
            end
            PARAM_REQ: begin
               bus.load_initial = 1'b1;
               state_d = PARAM_WAIT;
            end
            PARAM_WAIT: begin
               if (bus.param_done) begin
                  state_d = RD_REQ;
                  row_d   = '0;
                  col_d   = '0;
                  x_d     = '0;
                  y_d     = '0;
                  shift_d = 1'b0;
               end
            end
            RD_REQ: begin
               bus.start_read = 1'b1;
               state_d = RD_WAIT;
            end
            RD_WAIT: begin
               if (bus.read_data_done)
                  state_d = LD_REQ;
            end
            LD_REQ: begin
               bus.start_load = 1'b1;
               state_d = LD_WAIT;
            end
            LD_WAIT: begin
               if (bus.load_done) begin
                  if (last_tap) begin
                     state_d = CALC_REQ;
                  end else begin
                     state_d = RD_REQ;
                     if (shift_q || col_q == T_MAX) begin
                        row_d = row_q + 1'b1;
                        if (!shift_q)
                           col_d = '0;
                     end else begin
                        col_d = col_q + 1'b1;
                     end
                  end
               end
            end
            CALC_REQ: begin
               bus.start_calc = 1'b1;
               state_d = CALC_WAIT;
            end
            CALC_WAIT: begin
               if (bus.calc_done)
                  state_d = WR_REQ;
            end
            WR_REQ: begin
               bus.start_write = 1'b1;
               state_d = WR_WAIT;
            end
            WR_WAIT: begin
               if (bus.write_done)
                  state_d = ADV;
            end
            ADV: begin
               if (x_q < X_MAX) begin
                  bus.start_shift = 1'b1;
                  state_d = RD_REQ;
                  x_d     = x_q + 1'b1;
                  shift_d = 1'b1;
                  row_d   = '0;
                  col_d   = T_MAX;
               end else if (y_q < Y_MAX) begin
                  state_d = RD_REQ;
                  x_d     = '0;
                  y_d     = y_q + 1'b1;
                  shift_d = 1'b0;
                  row_d   = '0;
                  col_d   = '0;
               end else begin
                  bus.done = 1'b1;
                  state_d  = IDLE;
                  x_d      = '0;
                  y_d      = '0;
                  shift_d  = 1'b0;
                  row_d    = '0;
                  col_d    = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.tap_row = row_q;
   assign bus.tap_col = col_q;
   assign bus.win_x   = x_q;
   assign bus.win_y   = y_q;
endmodule
